u_ifu_q: RTL and testbench
==========================

// Module: u_ifu_q
// PURPOSE
//  Parametrised instruction fetch unit with a decoupled fetch queue. Generates sequential PCs,
//  drives the 1-cycle-latency instruction SRAM and buffers returned {pc,ins} in a QDEPTH FIFO.
//  Delivers to decode over a valid/ready handshake, so decode back-pressure stalls fetch.
//  Supports redirect (branch/jump target) and flush (replay from the oldest undelivered PC).
// PARAMETERS
//  AW        16     SRAM byte-address width (ins_a = pc[AW-1:0])
//  RESET_PC  32'h0  PC fetched first after reset release; bits [1:0] must be 0
//  QDEPTH    4      fetch queue entries; power of 2, >=2 (>=3 required for 1 ins/cycle)
// PORTS
//  clk          in   1   clock, all logic posedge
//  rst          in   1   asynchronous, active-high reset
//  flush        in   1   squash queue + in-flight, refetch from replay PC
//  redirect     in   1   squash queue + in-flight, refetch from redirect_pc
//  redirect_pc  in   32  redirect target; bits [1:0] ignored (forced 0)
//  ifu_vld      out  1   head entry valid
//  ifu_rdy      in   1   decode accepts head this cycle
//  ifu_pc       out  32  PC of head entry
//  ifu_ins      out  32  instruction of head entry
//  ins_a        out  AW  SRAM byte address
//  ins_e        out  1   SRAM read enable
//  ins          in   32  SRAM read data, valid the cycle after ins_e=1
// BEHAVIOUR
//  Reset (async, rst=1): pc=RESET_PC, queue empty, in-flight cleared; ifu_vld=0, ifu_pc=0,
//   ifu_ins=0, ins_e=0, ins_a=RESET_PC[AW-1:0]. Queue storage also resets to 0.
//  Issue: ins_e=1 iff !rst && !redirect && !flush && (occ + infl) < QDEPTH. occ = queue count,
//   infl = 1 if a read was issued last cycle and not killed. Same-cycle pop is NOT credited.
//   On issue: ins_a=pc[AW-1:0], infl_pc<=pc, pc<=pc+4 (32-bit wrap, FFFF_FFFC -> 0).
//  Response: cycle after issue, if not killed, {infl_pc, ins} is pushed; it is visible at
//   ifu_vld/ifu_pc/ifu_ins the following cycle. Issue-to-ifu_vld latency = 2 cycles.
//  Output: ifu_vld = occ!=0; head shown combinationally from FIFO; pop on ifu_vld && ifu_rdy.
//   ifu_pc/ifu_ins held stable while ifu_vld && !ifu_rdy. Push and pop in the same cycle allowed.
//  Redirect (cycle N): queue cleared at end of N; response arriving in N+1 dropped (kill);
//   ins_e=0 in N; pc<=redirect_pc&~3; first issue N+1 with ins_a=target; ifu_vld=0 in N+1..N+2.
//  Flush (no redirect): as redirect but pc <= replay PC = occ!=0 ? head pc
//   : (infl ? infl_pc : pc). No instruction is lost or duplicated to decode.
//  redirect && flush same cycle: redirect_pc wins. redirect/flush during stall: queue still cleared.
//  Queue never overflows (credit rule); push when full or pop when empty is an assertion error.
//  Reset asserted mid-operation: state returns to reset values immediately; in-flight data dropped.
// STRUCTURE
//  Package u_ifu_pkg: typedef struct packed {logic [31:0] pc; logic [31:0] ins;} fetch_ent_t;
//   localparam INS_BYTES=4. The top level passes QDEPTH to the FIFO.
//  Sub-module u_fifo_sync #(type T, DEPTH): push/pop/clr, full/empty/count, async active-high
//   reset, head data read combinationally. All other logic (PC, credit, kill) sits in u_ifu_q.
// TESTING
//  1 Reset release, ifu_rdy=1, SRAM model returns ins=addr^32'hA5A5_0000 -> issues at 0,4,8.. one per cycle;
//    ifu_vld rises 2 cycles after first ins_e; ifu_pc=0,4,8 back-to-back, ins matches model.
//  2 ifu_rdy=0 for 10 cycles with QDEPTH=4 -> ins_e stops after occ+infl=4; ifu_pc=0 held;
//    rdy=1 resumes pc 0,4,8,12,16 with no gap or duplicate.
//  3 redirect=1, redirect_pc=32'h0000_0103 while 3 entries queued -> next ins_a=16'h0100; stale
//    response dropped; next delivered ifu_pc=32'h0000_0100, no older PC seen afterwards.
//  4 flush with head pc=32'h20 queued, rdy=0 -> queue empties; refetch starts at 32'h20; delivery
//    order 20,24,28 (no loss/duplication).
//  5 redirect and flush same cycle, redirect_pc=32'h40 -> refetch from 32'h40.
//  6 RESET_PC=32'hFFFF_FFF8 -> delivered PCs FFFF_FFF8, FFFF_FFFC, 0000_0000 (wrap); rst pulsed
//    mid-stream -> ifu_vld=0 at once, restart at RESET_PC.

Source files
------------

// File: rtl/u_ifu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : u_ifu_pkg
// Description : Shared types and constants for the instruction fetch unit.
// Revision    : 1.0 - initial release
// ============================================================================
package u_ifu_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } fetch_ent_t;

    localparam int INS_BYTES = 4;

endpackage
`default_nettype wire

// File: rtl/u_fifo_sync.sv
`default_nettype none
// ============================================================================
// Module      : u_fifo_sync
// Description : Synchronous FIFO with clear, combinational head read.
// Revision    : 1.0 - initial release
// ============================================================================
module u_fifo_sync #(
    parameter type T     = logic [63:0],
    parameter int  DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clr,
    input  T                         din,
    output T                         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int            PW      = $clog2(DEPTH);
    localparam logic [PW:0]   C_DEPTH = DEPTH[PW:0];

    T              r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [PW:0]   r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (clr) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (push) begin
                r_mem[r_wptr] <= din;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign dout  = r_mem[r_rptr];
    assign count = r_count;
    assign full  = (r_count == C_DEPTH);
    assign empty = (r_count == '0);

    a_no_overflow:  assert property (@(posedge clk) disable iff (rst) !(push && full));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(pop && empty));

endmodule
`default_nettype wire

// File: rtl/u_ifu_q.sv
`default_nettype none
// ============================================================================
// Module      : u_ifu_q
// Description : Instruction fetch unit with credit-controlled decoupled queue.
// Revision    : 1.0 - initial release
// ============================================================================
module u_ifu_q
    import u_ifu_pkg::*;
#(
    parameter int          AW       = 16,
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          QDEPTH   = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          redirect,
    input  logic [31:0]   redirect_pc,
    output logic          ifu_vld,
    input  logic          ifu_rdy,
    output logic [31:0]   ifu_pc,
    output logic [31:0]   ifu_ins,
    output logic [AW-1:0] ins_a,
    output logic          ins_e,
    input  logic [31:0]   ins
);

    localparam int          CW       = $clog2(QDEPTH) + 1;
    localparam logic [CW:0] C_QDEPTH = QDEPTH[CW:0];

    logic [31:0]   r_pc;
    logic [31:0]   r_infl_pc;
    logic          r_infl;

    logic          w_kill;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic [CW:0]   w_credit;
    logic [31:0]   w_replay_pc;
    fetch_ent_t    w_din;
    fetch_ent_t    w_head;

    assign w_kill = redirect | flush;

    // A pop in the same cycle is deliberately not credited: keeps the issue path
    // independent of decode's ready.
    assign w_credit = {1'b0, w_count} + {{CW{1'b0}}, r_infl};
    assign ins_e    = !rst && !w_kill && (w_credit < C_QDEPTH);
    assign ins_a    = r_pc[AW-1:0];

    // Oldest PC not yet handed to decode: queue head, else the in-flight read.
    assign w_replay_pc = !w_empty ? w_head.pc : (r_infl ? r_infl_pc : r_pc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc      <= RESET_PC;
            r_infl    <= 1'b0;
            r_infl_pc <= '0;
        end else begin
            r_infl <= ins_e;
            if (redirect) begin
                r_pc <= redirect_pc & ~32'h3;
            end else if (flush) begin
                r_pc <= w_replay_pc;
            end else if (ins_e) begin
                r_infl_pc <= r_pc;
                r_pc      <= r_pc + 32'(INS_BYTES);
            end
        end
    end

    assign w_push    = r_infl && !w_kill;
    assign w_pop     = ifu_vld && ifu_rdy;
    assign w_din.pc  = r_infl_pc;
    assign w_din.ins = ins;

    u_fifo_sync #(
        .T     (fetch_ent_t),
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .clr   (w_kill),
        .din   (w_din),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    assign ifu_vld = !w_empty;
    assign ifu_pc  = w_head.pc;
    assign ifu_ins = w_head.ins;

    a_credit_ok: assert property (@(posedge clk) disable iff (rst) !(w_push && w_full));

endmodule
`default_nettype wire

// File: tb/tb_u_ifu_q.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_u_ifu_q
// Description : Self-checking bench for u_ifu_q (vector table + scoreboard).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_u_ifu_q;
    import u_ifu_pkg::*;

    localparam logic [31:0] C_XOR = 32'hA5A5_0000;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, flush = 1'b0, redirect = 1'b0, ifu_rdy = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        ifu_vld, ins_e;
    logic [31:0] ifu_pc, ifu_ins, ins;
    logic [15:0] ins_a;

    u_ifu_q #(.AW(16), .RESET_PC(32'h0), .QDEPTH(4)) dut (
        .clk(clk), .rst(rst), .flush(flush), .redirect(redirect),
        .redirect_pc(redirect_pc), .ifu_vld(ifu_vld), .ifu_rdy(ifu_rdy),
        .ifu_pc(ifu_pc), .ifu_ins(ifu_ins), .ins_a(ins_a), .ins_e(ins_e), .ins(ins)
    );

    logic        rst6 = 1'b1, rdy6 = 1'b0, vld6, e6;
    logic [31:0] pc6, ins6_o, ins6;
    logic [15:0] a6;

    u_ifu_q #(.AW(16), .RESET_PC(32'hFFFF_FFF8), .QDEPTH(4)) dut6 (
        .clk(clk), .rst(rst6), .flush(1'b0), .redirect(1'b0),
        .redirect_pc(32'h0), .ifu_vld(vld6), .ifu_rdy(rdy6),
        .ifu_pc(pc6), .ifu_ins(ins6_o), .ins_a(a6), .ins_e(e6), .ins(ins6)
    );

    // SRAM models: one-cycle read latency
    always @(posedge clk) if (ins_e) ins  <= {16'h0, ins_a} ^ C_XOR;
    always @(posedge clk) if (e6)    ins6 <= {16'h0, a6} ^ C_XOR;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] sram_of(input logic [31:0] pc);
        return {16'h0, pc[15:0]} ^ C_XOR;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: holds queued + in-flight fetches in program order
    fetch_ent_t  sb[$];
    logic [31:0] m_pc = 32'h0;

    always @(negedge clk) begin : mon
        fetch_ent_t e;
        if (rst) begin
            sb.delete();
            m_pc = 32'h0;
        end else if (redirect || flush) begin
            chk("sb no issue on kill", 32'(ins_e), 32'd0);
            if (redirect)         m_pc = redirect_pc & ~32'h3;
            else if (sb.size() != 0) m_pc = sb[0].pc;
            sb.delete();
        end else begin
            if (ifu_vld && ifu_rdy) begin
                if (sb.size() == 0) begin
                    chk("sb unexpected delivery", ifu_pc, 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk("sb ifu_pc", ifu_pc, e.pc);
                    chk("sb ifu_ins", ifu_ins, e.ins);
                end
            end
            if (ins_e) begin
                chk("sb ins_a", 32'(ins_a), 32'(m_pc[15:0]));
                e.pc  = m_pc;
                e.ins = sram_of(m_pc);
                sb.push_back(e);
                m_pc = m_pc + 32'd4;
            end
        end
    end

    typedef struct {
        logic        r;
        logic        rdy;
        logic        e;
        logic        ca;
        logic [15:0] a;
        logic        v;
        logic [31:0] pc;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic rdy, input logic e, input logic ca,
                       input logic [15:0] a, input logic v, input logic [31:0] pc);
        vec_t t;
        t.r = r; t.rdy = rdy; t.e = e; t.ca = ca; t.a = a; t.v = v; t.pc = pc;
        tbl.push_back(t);
    endtask

    initial begin
        // Streaming with decode always ready
        add(1, 1, 0, 1, 16'h0000, 0, 32'h0);
        add(0, 1, 1, 1, 16'h0000, 0, 32'h0);
        add(0, 1, 1, 1, 16'h0004, 0, 32'h0);
        add(0, 1, 1, 1, 16'h0008, 1, 32'h0);
        add(0, 1, 1, 1, 16'h000C, 1, 32'h4);
        add(0, 1, 1, 1, 16'h0010, 1, 32'h8);
        add(0, 1, 1, 1, 16'h0014, 1, 32'hC);
        // Back-pressure from reset: 10 stalled cycles then resume
        add(1, 0, 0, 1, 16'h0000, 0, 32'h0);
        add(0, 0, 1, 1, 16'h0000, 0, 32'h0);
        add(0, 0, 1, 1, 16'h0004, 0, 32'h0);
        add(0, 0, 1, 1, 16'h0008, 1, 32'h0);
        add(0, 0, 1, 1, 16'h000C, 1, 32'h0);
        for (int k = 0; k < 6; k++) add(0, 0, 0, 0, 16'h0, 1, 32'h0);
        add(0, 1, 0, 0, 16'h0000, 1, 32'h0);
        add(0, 1, 1, 1, 16'h0010, 1, 32'h4);
        add(0, 1, 1, 1, 16'h0014, 1, 32'h8);
        add(0, 1, 1, 1, 16'h0018, 1, 32'hC);
        add(0, 1, 1, 1, 16'h001C, 1, 32'h10);
        add(0, 1, 1, 1, 16'h0020, 1, 32'h14);

        foreach (tbl[i]) begin
            step();
            rst     = tbl[i].r;
            ifu_rdy = tbl[i].rdy;
            @(negedge clk);
            chk($sformatf("v%0d ins_e", i), 32'(ins_e), 32'(tbl[i].e));
            if (tbl[i].ca) chk($sformatf("v%0d ins_a", i), 32'(ins_a), 32'(tbl[i].a));
            chk($sformatf("v%0d ifu_vld", i), 32'(ifu_vld), 32'(tbl[i].v));
            if (tbl[i].v || tbl[i].r) chk($sformatf("v%0d ifu_pc", i), ifu_pc, tbl[i].pc);
            if (tbl[i].r) chk($sformatf("v%0d ifu_ins", i), ifu_ins, 32'h0);
        end

        // Redirect with a full queue
        step(); ifu_rdy = 1'b0;
        repeat (4) step();
        @(negedge clk); chk("redir queued", 32'(ifu_vld), 32'd1);
        step(); redirect = 1'b1; redirect_pc = 32'h0000_0103;
        @(negedge clk); chk("redir ins_e N", 32'(ins_e), 32'd0);
        step(); redirect = 1'b0;
        @(negedge clk);
        chk("redir ins_e N+1", 32'(ins_e), 32'd1);
        chk("redir ins_a", 32'(ins_a), 32'h0100);
        chk("redir vld N+1", 32'(ifu_vld), 32'd0);
        step(); @(negedge clk); chk("redir vld N+2", 32'(ifu_vld), 32'd0);
        step(); ifu_rdy = 1'b1;
        @(negedge clk);
        chk("redir vld N+3", 32'(ifu_vld), 32'd1);
        chk("redir pc", ifu_pc, 32'h0000_0100);
        repeat (4) step();

        // Flush while stalled with head pc 0x20
        step(); ifu_rdy = 1'b0; redirect = 1'b1; redirect_pc = 32'h20;
        step(); redirect = 1'b0;
        repeat (3) step();
        @(negedge clk); chk("flush head", ifu_pc, 32'h20);
        step(); flush = 1'b1;
        @(negedge clk); chk("flush ins_e N", 32'(ins_e), 32'd0);
        step(); flush = 1'b0;
        @(negedge clk);
        chk("flush ins_a", 32'(ins_a), 32'h0020);
        chk("flush vld N+1", 32'(ifu_vld), 32'd0);
        step(); @(negedge clk); chk("flush vld N+2", 32'(ifu_vld), 32'd0);
        step(); ifu_rdy = 1'b1;
        @(negedge clk); chk("flush pc0", ifu_pc, 32'h20);
        step(); @(negedge clk); chk("flush pc1", ifu_pc, 32'h24);
        step(); @(negedge clk); chk("flush pc2", ifu_pc, 32'h28);

        // Redirect and flush together: redirect target wins
        step(); ifu_rdy = 1'b0; redirect = 1'b1; flush = 1'b1; redirect_pc = 32'h40;
        @(negedge clk); chk("both ins_e N", 32'(ins_e), 32'd0);
        step(); redirect = 1'b0; flush = 1'b0;
        @(negedge clk); chk("both ins_a", 32'(ins_a), 32'h0040);
        step();
        step(); ifu_rdy = 1'b1;
        @(negedge clk);
        chk("both vld", 32'(ifu_vld), 32'd1);
        chk("both pc", ifu_pc, 32'h40);
        repeat (3) step();

        // PC wrap from RESET_PC near the top, then mid-stream reset
        step(); rst6 = 1'b0; rdy6 = 1'b1;
        @(negedge clk);
        chk("wrap ins_e", 32'(e6), 32'd1);
        chk("wrap ins_a", 32'(a6), 32'hFFF8);
        step(); step(); @(negedge clk);
        chk("wrap vld", 32'(vld6), 32'd1);
        chk("wrap pc0", pc6, 32'hFFFF_FFF8);
        chk("wrap ins0", ins6_o, 32'h0000_FFF8 ^ C_XOR);
        step(); @(negedge clk);
        chk("wrap pc1", pc6, 32'hFFFF_FFFC);
        chk("wrap ins1", ins6_o, 32'h0000_FFFC ^ C_XOR);
        step(); @(negedge clk);
        chk("wrap pc2", pc6, 32'h0000_0000);
        chk("wrap ins2", ins6_o, C_XOR);
        step(); rst6 = 1'b1; #1;
        chk("rst vld", 32'(vld6), 32'd0);
        chk("rst pc", pc6, 32'h0);
        chk("rst ins_e", 32'(e6), 32'd0);
        chk("rst ins_a", 32'(a6), 32'hFFF8);
        step(); rst6 = 1'b0;
        @(negedge clk);
        chk("restart ins_a", 32'(a6), 32'hFFF8);
        chk("restart vld", 32'(vld6), 32'd0);
        step(); step(); @(negedge clk);
        chk("restart pc", pc6, 32'hFFFF_FFF8);

        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
